// File: rtl/ir_prefetch_queue.sv
// Instruction register fed by a small prefetch FIFO. The IR loads from the oldest queued word,
// or straight from in_data when the queue is empty. Flush drops the queue and the IR.
module ir_prefetch_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          ir_load,
  input  logic          flush,
  output logic [W-1:0]  ir,
  output logic          ir_valid,
  output logic [5:0]    opcode,
  output logic [4:0]    rs,
  output logic [4:0]    rt,
  output logic [4:0]    rd,
  output logic [4:0]    shamt,
  output logic [5:0]    funct,
  output logic [15:0]   imm,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          push;
  logic          pop;
  logic          bypass;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !full;

  // A bypassed word goes straight to the IR and must not also be queued.
  assign bypass = ir_load && empty && in_valid;
  assign push   = in_valid && in_ready && !flush && !bypass;
  assign pop    = ir_load && !empty && !flush;

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= wptr;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (flush) begin
      ir       <= '0;
      ir_valid <= 1'b0;
    end else if (ir_load) begin
      if (!empty) begin
        ir       <= mem[rptr];
        ir_valid <= 1'b1;
      end else if (in_valid) begin
        ir       <= in_data;
        ir_valid <= 1'b1;
      end else begin
        ir_valid <= 1'b0;
      end
    end
  end

  assign opcode = ir[31:26];
  assign rs     = ir[25:21];
  assign rt     = ir[20:16];
  assign rd     = ir[15:11];
  assign shamt  = ir[10:6];
  assign funct  = ir[5:0];
  assign imm    = ir[15:0];

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Bench for ir_prefetch_queue: constant vector table for fill/drain, a queue-based reference
// model for the concurrent/wrap traffic, and hand sequences for reset, bypass and flush.
module tb_ir_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        ir_load;
  logic        flush;
  logic [31:0] ir;
  logic        ir_valid;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  ir_prefetch_queue #(.W(32), .DEPTH(4), .CW(3)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .ir_load(ir_load), .flush(flush), .ir(ir), .ir_valid(ir_valid), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct), .imm(imm),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  logic [31:0] mq[$];
  logic [31:0] m_ir;
  logic        m_valid;

  typedef struct {
    logic        iv;
    logic [31:0] d;
    logic        ld;
    logic        fl;
    int          ecount;
    logic        evalid;
    logic [31:0] eir;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the reference model, then compare after the edge.
  task automatic step(input logic iv, input logic [31:0] d, input logic ld, input logic fl);
    bit m_full, m_empty;
    in_valid = iv;
    in_data  = d;
    ir_load  = ld;
    flush    = fl;
    m_full  = (mq.size() == 4);
    m_empty = (mq.size() == 0);
    #1;
    check("in_ready", {31'b0, in_ready}, {31'b0, !m_full});
    @(posedge clk);
    if (fl) begin
      mq.delete();
      m_ir    = '0;
      m_valid = 1'b0;
    end else begin
      if (ld) begin
        if (!m_empty) begin
          m_ir    = mq.pop_front();
          m_valid = 1'b1;
        end else if (iv) begin
          m_ir    = d;
          m_valid = 1'b1;
        end else begin
          m_valid = 1'b0;
        end
      end
      if (iv && !m_full && !(ld && m_empty)) mq.push_back(d);
    end
    #1;
    check("model_ir", ir, m_ir);
    check("model_ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
    check("model_count", {29'b0, count}, mq.size());
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr + 1);
    $fatal(1);
  end

  initial begin
    logic [31:0] fill_exp;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; ir_load = 1'b0; flush = 1'b0;
    m_ir = '0; m_valid = 1'b0;

    // T2 fill then T3 drain, as a constant table
    tbl[0] = '{1'b1, 32'h2008_0001, 1'b0, 1'b0, 1, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 32'h2008_0002, 1'b0, 1'b0, 2, 1'b0, 32'h0};
    tbl[2] = '{1'b1, 32'h2008_0003, 1'b0, 1'b0, 3, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 32'h2008_0004, 1'b0, 1'b0, 4, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 32'h2008_0005, 1'b0, 1'b0, 4, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 32'h0,         1'b1, 1'b0, 3, 1'b1, 32'h2008_0001};
    tbl[6] = '{1'b0, 32'h0,         1'b1, 1'b0, 2, 1'b1, 32'h2008_0002};
    tbl[7] = '{1'b0, 32'h0,         1'b1, 1'b0, 1, 1'b1, 32'h2008_0003};
    tbl[8] = '{1'b0, 32'h0,         1'b1, 1'b0, 0, 1'b1, 32'h2008_0004};

    #1;
    check("rst_ir", ir, 32'h0);
    check("rst_ir_valid", {31'b0, ir_valid}, 32'h0);
    check("rst_count", {29'b0, count}, 32'h0);
    check("rst_empty", {31'b0, empty}, 32'h1);
    check("rst_full", {31'b0, full}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("rst_opcode", {26'b0, opcode}, 32'h0);
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].iv, tbl[i].d, tbl[i].ld, tbl[i].fl);
      check($sformatf("tbl%0d_count", i), {29'b0, count}, tbl[i].ecount);
      check($sformatf("tbl%0d_ir_valid", i), {31'b0, ir_valid}, {31'b0, tbl[i].evalid});
      check($sformatf("tbl%0d_ir", i), ir, tbl[i].eir);
      if (i == 4) begin
        check("t2_full", {31'b0, full}, 32'h1);
        check("t2_in_ready", {31'b0, in_ready}, 32'h0);
      end
      if (i >= 5) begin
        fill_exp = tbl[i].eir;
        check("t3_opcode", {26'b0, opcode}, 32'h08);
        check("t3_rt", {27'b0, rt}, 32'h08);
        check("t3_imm", {16'b0, imm}, {16'b0, fill_exp[15:0]});
      end
    end
    check("t3_empty", {31'b0, empty}, 32'h1);

    // T4: concurrent push/load at count=2, pointers wrap several times
    step(1'b1, 32'h2008_0100, 1'b0, 1'b0);
    step(1'b1, 32'h2008_0101, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'h2008_0102 + i, 1'b1, 1'b0);
      check("t4_count", {29'b0, count}, 32'h2);
      check("t4_ir", ir, 32'h2008_0100 + i);
    end

    // T5: drain, then bypass and bubble
    step(1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t5_empty", {31'b0, empty}, 32'h1);
    step(1'b1, 32'h012A_4020, 1'b1, 1'b0);
    check("t5_bypass_ir", ir, 32'h012A_4020);
    check("t5_bypass_valid", {31'b0, ir_valid}, 32'h1);
    check("t5_funct", {26'b0, funct}, 32'h20);
    check("t5_rd", {27'b0, rd}, 32'h8);
    check("t5_count", {29'b0, count}, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t5_bubble_valid", {31'b0, ir_valid}, 32'h0);
    check("t5_bubble_ir", ir, 32'h012A_4020);

    // T6: flush beats a same-cycle load and push
    step(1'b1, 32'h1111_0001, 1'b0, 1'b0);
    step(1'b1, 32'h1111_0002, 1'b0, 1'b0);
    step(1'b1, 32'h1111_0003, 1'b0, 1'b0);
    check("t6_pre_count", {29'b0, count}, 32'h3);
    step(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1);
    check("t6_count", {29'b0, count}, 32'h0);
    check("t6_ir", ir, 32'h0);
    check("t6_ir_valid", {31'b0, ir_valid}, 32'h0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t6_nothing_stored", {31'b0, ir_valid}, 32'h0);

    // T1: async reset mid-stream, no clock edge
    step(1'b1, 32'h2222_0001, 1'b0, 1'b0);
    step(1'b1, 32'h2222_0002, 1'b1, 1'b0);
    check("t1_pre_valid", {31'b0, ir_valid}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t1_ir", ir, 32'h0);
    check("t1_ir_valid", {31'b0, ir_valid}, 32'h0);
    check("t1_count", {29'b0, count}, 32'h0);
    check("t1_empty", {31'b0, empty}, 32'h1);
    check("t1_in_ready", {31'b0, in_ready}, 32'h1);
    check("t1_funct", {26'b0, funct}, 32'h0);
    mq.delete(); m_ir = '0; m_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 32'h0, 1'b1, 1'b0);
    check("t1_post_valid", {31'b0, ir_valid}, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
